dmb_fifo_rdout_sched: RTL and testbench
=======================================

DMB_FIFO_RDOUT_SCHED -- requirements
Module: dmb_fifo_rdout_sched

Interface
REQ-001 The block SHALL have parameter TMR, default 0: when 1, the FSM state, mask and timeout registers are triplicated with majority vote.
REQ-002 The block SHALL have parameter TIMEOUT, default 255: number of idle READ cycles, 1..255, before a FIFO is abandoned.
REQ-003 CLK  in  1  CMS clock; all logic on rising edge.
REQ-004 RST_B  in  1  Reset, synchronous and active-low.
REQ-005 START  in  1  Event available, i.e. global trigger FIFO non-empty; level input, sampled in IDLE only.
REQ-006 DAVMASK  in  7  FIFOs holding data for this event, bit 0 = FIFO1; captured on accepted START.
REQ-007 FFOR_B  in  7  Per-FIFO output ready, active-low.
REQ-008 LAST  in  1  End-of-event flag of the word currently presented by the selected FIFO.
REQ-009 HOLD  in  1  Downstream backpressure; no read is issued while high.
REQ-010 REN_B  out  7  Per-FIFO read enable, active-low, registered.
REQ-011 OE_B  out  7  Per-FIFO output enable, active-low, registered.
REQ-012 DV  out  1  Word-read strobe, high in the cycle REN_B is low and the word is consumed.
REQ-013 BUSY  out  1  High from accepted START until DONE inclusive.
REQ-014 DONE  out  1  One-cycle pulse at end of event.
REQ-015 POP  out  1  One-cycle pulse coincident with DONE, pops the trigger FIFO.
REQ-016 TMOERR  out  7  Per-FIFO timeout flags for the last event.
REQ-017 WCNT  out  16  Words read in the current event.

Function
REQ-018 The FSM SHALL have states IDLE, SELECT, OESETUP, READ, NEXT and FINISH.
REQ-019 IDLE with START=1 SHALL go to SELECT, capture DAVMASK into MASK, clear WCNT and TMOERR, and set BUSY.
REQ-020 SELECT SHALL choose the lowest-index set MASK bit i and go to OESETUP; with MASK=0 it SHALL go to FINISH.
REQ-021 OESETUP SHALL drive OE_B[i]=0 for exactly 1 cycle before READ; no REN_B is low in OESETUP.
REQ-022 READ SHALL drive REN_B[i]=0 in every cycle where FFOR_B[i]=0 and HOLD=0, and SHALL drive REN_B=7'h7F otherwise.
REQ-023 DV SHALL equal ~REN_B[i] in every cycle.
REQ-024 WCNT SHALL increment on each DV and saturate at 16'hFFFF.
REQ-025 A DV cycle with LAST=1 SHALL be the final read, and the next state SHALL be NEXT.
REQ-026 In READ, a timeout counter SHALL count cycles without DV and clear on any DV.
REQ-027 When the timeout counter reaches TIMEOUT, the block SHALL set TMOERR[i] and go to NEXT without reading.
REQ-028 NEXT SHALL drive OE_B=7'h7F and REN_B=7'h7F, clear MASK[i], and go to SELECT.
REQ-029 FINISH SHALL pulse DONE and POP for 1 cycle, deassert BUSY on the following cycle and return to IDLE.
REQ-030 At most one OE_B bit and one REN_B bit SHALL be low in any cycle.
REQ-031 OE_B[i] SHALL be low in every cycle REN_B[i] is low.
REQ-032 START arriving while BUSY SHALL be ignored; it is re-evaluated in IDLE.
REQ-033 HOLD rising in the same cycle as LAST SHALL still complete the LAST read, since REN_B was already registered low.
REQ-034 TMOERR and WCNT SHALL hold their value after DONE until the next accepted START.

Reset
REQ-035 When RST_B=0 at a rising edge, the following SHALL reset: state=IDLE, REN_B=7'h7F, OE_B=7'h7F, DV=0, BUSY=0, DONE=0, POP=0, TMOERR=0, WCNT=0, MASK=0, timeout counter=0.
REQ-036 Reset mid-event SHALL abort the event without POP, and outputs SHALL be inactive from the first reset edge.

Structure
REQ-037 The FSM state encoding, NFIFO=7 and the all-disabled constant 7'h7F SHALL live in the shared DMB package.
REQ-038 The lowest-index-first selector SHALL be a sub-module, prio_enc7, with input 7-bit mask and outputs 3-bit index and valid.
REQ-039 TMR voting SHALL reuse the codebase's existing voter cells.

Verification
REQ-040 Bench SHALL apply DAVMASK=7'b0000101 with 3 words per FIFO, FFOR_B low and LAST on word 3; required response: FIFO1 is read then FIFO3, DV count = 6, WCNT=6, a single DONE/POP pulse, TMOERR=0.
REQ-041 Bench SHALL apply DAVMASK=0; required response: DONE and POP occur 2 cycles after START is accepted, WCNT=0.
REQ-042 Bench SHALL apply DAVMASK=7'b0000010 with FFOR_B[1] held high and TIMEOUT=8; required response: TMOERR=7'b0000010 after 8 READ cycles, then DONE.
REQ-043 Bench SHALL toggle HOLD every other cycle during a 10-word read; required response: REN_B low only in HOLD=0 cycles, WCNT=10.
REQ-044 Bench SHALL drive RST_B=0 during READ of the 2nd FIFO; required response: REN_B and OE_B are all 1 next edge, no POP, state IDLE.
REQ-045 Bench SHALL check every cycle of every scenario that at most one REN_B bit and one OE_B bit are low, and that OE_B precedes REN_B by at least 1 cycle.

Source files
------------

// File: rtl/dmb_fifo_rdout_sched_pkg.sv
// Shared DMB definitions: FIFO count, disabled-enable constant, scheduler state
// encoding and the majority voter cells used by triplicated registers.
package dmb_fifo_rdout_sched_pkg;

    localparam int               NFIFO   = 7;
    localparam logic [NFIFO-1:0] ALL_OFF = 7'h7F;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SELECT  = 3'd1;
    localparam logic [2:0] ST_OESETUP = 3'd2;
    localparam logic [2:0] ST_READ    = 3'd3;
    localparam logic [2:0] ST_NEXT    = 3'd4;
    localparam logic [2:0] ST_FINISH  = 3'd5;

    // Bitwise two-out-of-three majority, one cell per register width.
    function automatic logic [2:0] vote3b(input logic [2:0] a, input logic [2:0] b,
                                          input logic [2:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [6:0] vote7b(input logic [6:0] a, input logic [6:0] b,
                                          input logic [6:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [7:0] vote8b(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/dmb_fifo_rdout_sched_prio_enc7.sv
// Lowest-index-first selector over the pending-FIFO mask.
module prio_enc7
    import dmb_fifo_rdout_sched_pkg::*;
(
    input  logic [NFIFO-1:0] mask_i,
    output logic [2:0]       idx_o,
    output logic             valid_o
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = 3'd0;
        valid_o = 1'b0;
        for (int k = NFIFO - 1; k >= 0; k--) begin
            if (mask_i[k]) begin
                idx_o   = 3'(k);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmb_fifo_rdout_sched.sv
// DMB FIFO readout scheduler: drains each FIFO flagged for an event in index
// order, with per-FIFO timeout and optional triplicated control registers.
module dmb_fifo_rdout_sched
    import dmb_fifo_rdout_sched_pkg::*;
#(
    parameter int TMR     = 0,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_b_i,
    input  logic             start_i,
    input  logic [NFIFO-1:0] davmask_i,
    input  logic [NFIFO-1:0] ffor_b_i,
    input  logic             last_i,
    input  logic             hold_i,
    output logic [NFIFO-1:0] ren_b_o,
    output logic [NFIFO-1:0] oe_b_o,
    output logic             dv_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pop_o,
    output logic [NFIFO-1:0] tmoerr_o,
    output logic [15:0]      wcnt_o
);

    localparam int         NCOPY    = (TMR != 0) ? 3 : 1;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [2:0]       state_q [NCOPY];
    logic [NFIFO-1:0] mask_q  [NCOPY];
    logic [7:0]       tmo_q   [NCOPY];
    logic [2:0]       state_v, state_d;
    logic [NFIFO-1:0] mask_v, mask_d;
    logic [7:0]       tmo_v, tmo_d;
    logic [2:0]       sel_q, sel_d;
    logic [NFIFO-1:0] ren_b_q, ren_b_d, oe_b_q, oe_b_d, tmoerr_q, tmoerr_d;
    logic [15:0]      wcnt_q, wcnt_d;
    logic [2:0]       pe_idx;
    logic             pe_valid;
    logic             dv;

    generate
        if (TMR != 0) begin : g_vote
            assign state_v = vote3b(state_q[0], state_q[1], state_q[2]);
            assign mask_v  = vote7b(mask_q[0], mask_q[1], mask_q[2]);
            assign tmo_v   = vote8b(tmo_q[0], tmo_q[1], tmo_q[2]);
        end else begin : g_single
            assign state_v = state_q[0];
            assign mask_v  = mask_q[0];
            assign tmo_v   = tmo_q[0];
        end
    endgenerate

    prio_enc7 u_prio (
        .mask_i  (mask_v),
        .idx_o   (pe_idx),
        .valid_o (pe_valid)
    );

    // Only the selected FIFO's enable can ever be low, so any low bit is a read.
    assign dv       = ~&ren_b_q;
    assign dv_o     = dv;
    assign ren_b_o  = ren_b_q;
    assign oe_b_o   = oe_b_q;
    assign busy_o   = (state_v != ST_IDLE);
    assign done_o   = (state_v == ST_FINISH);
    assign pop_o    = (state_v == ST_FINISH);
    assign tmoerr_o = tmoerr_q;
    assign wcnt_o   = wcnt_q;

    always_comb begin
        state_d  = state_v;
        mask_d   = mask_v;
        tmo_d    = tmo_v;
        sel_d    = sel_q;
        tmoerr_d = tmoerr_q;
        wcnt_d   = wcnt_q;
        if (dv && (wcnt_q != 16'hFFFF)) begin
            wcnt_d = wcnt_q + 16'd1;
        end
        case (state_v)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_SELECT;
                    mask_d   = davmask_i;
                    wcnt_d   = '0;
                    tmoerr_d = '0;
                end
            end
            ST_SELECT: begin
                if (pe_valid) begin
                    sel_d   = pe_idx;
                    state_d = ST_OESETUP;
                end else begin
                    state_d = ST_FINISH;
                end
            end
            ST_OESETUP: begin
                state_d = ST_READ;
                tmo_d   = '0;
            end
            ST_READ: begin
                // A read in flight always wins over the timeout.
                if (dv) begin
                    tmo_d = '0;
                    if (last_i) begin
                        state_d = ST_NEXT;
                    end
                end else if (tmo_v == TMO_LAST) begin
                    tmo_d           = '0;
                    tmoerr_d[sel_q] = 1'b1;
                    state_d         = ST_NEXT;
                end else begin
                    tmo_d = tmo_v + 8'd1;
                end
            end
            ST_NEXT: begin
                mask_d[sel_q] = 1'b0;
                state_d       = ST_SELECT;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Enables are registered from the next state, so OE leads REN by OESETUP.
    always_comb begin
        oe_b_d  = ALL_OFF;
        ren_b_d = ALL_OFF;
        if ((state_d == ST_OESETUP) || (state_d == ST_READ)) begin
            oe_b_d[sel_d] = 1'b0;
        end
        if ((state_v == ST_READ) && (state_d == ST_READ) && !ffor_b_i[sel_q] && !hold_i) begin
            ren_b_d[sel_q] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NCOPY; k++) begin
            if (!rst_b_i) begin
                state_q[k] <= ST_IDLE;
                mask_q[k]  <= '0;
                tmo_q[k]   <= '0;
            end else begin
                state_q[k] <= state_d;
                mask_q[k]  <= mask_d;
                tmo_q[k]   <= tmo_d;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_b_i) begin
            sel_q    <= '0;
            ren_b_q  <= ALL_OFF;
            oe_b_q   <= ALL_OFF;
            tmoerr_q <= '0;
            wcnt_q   <= '0;
        end else begin
            sel_q    <= sel_d;
            ren_b_q  <= ren_b_d;
            oe_b_q   <= oe_b_d;
            tmoerr_q <= tmoerr_d;
            wcnt_q   <= wcnt_d;
        end
    end

endmodule

// File: tb/tb_dmb_fifo_rdout_sched.sv
// Scoreboard bench for the readout scheduler: events are queued as expected
// read sequences and end records, a negedge monitor drains and compares them.
module tb_dmb_fifo_rdout_sched;

    localparam int TMO = 8;

    typedef struct {
        int         wcnt;
        logic [6:0] tmo;
        bit         zeroMask;
    } endRec_t;

    logic        clk = 1'b0;
    logic        rstB;
    logic        startI;
    logic [6:0]  davmaskI;
    logic [6:0]  fforB;
    logic        lastI;
    logic        holdI;
    logic [6:0]  renB;
    logic [6:0]  oeB;
    logic        dv;
    logic        busy;
    logic        done;
    logic        pop;
    logic [6:0]  tmoerr;
    logic [15:0] wcnt;

    int      passCount = 0;
    int      checkCount = 0;
    int      expDv[$];
    endRec_t expEnd[$];
    int      loaded[7];
    int      consumed[7];
    int      oeRun[7];
    int      stimMode = 0;
    int      cycle = 0;
    int      doneSeen = 0;
    int      acceptCycle = 0;
    int      stallRun = 0;
    logic    prevHold = 1'b0;
    logic    prevDone = 1'b0;
    logic [6:0] prevOeLow = '0;

    always #5 clk = ~clk;

    dmb_fifo_rdout_sched #(
        .TMR     (0),
        .TIMEOUT (TMO)
    ) dut (
        .clk_i     (clk),
        .rst_b_i   (rstB),
        .start_i   (startI),
        .davmask_i (davmaskI),
        .ffor_b_i  (fforB),
        .last_i    (lastI),
        .hold_i    (holdI),
        .ren_b_o   (renB),
        .oe_b_o    (oeB),
        .dv_o      (dv),
        .busy_o    (busy),
        .done_o    (done),
        .pop_o     (pop),
        .tmoerr_o  (tmoerr),
        .wcnt_o    (wcnt)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cycle);
        end
    endtask

    // Monitor and FIFO environment share one negedge process so that LAST and
    // FFOR are derived from the word counts before this cycle's read is retired.
    always @(negedge clk) begin : monitor
        logic [6:0] renLow, oeLow;
        int         renIdx, oeIdx;
        logic       holdNext, fforStall;
        endRec_t    e;
        cycle++;
        renLow = ~renB;
        oeLow  = ~oeB;
        renIdx = -1;
        oeIdx  = -1;
        for (int k = 6; k >= 0; k--) begin
            if (renLow[k]) renIdx = k;
            if (oeLow[k])  oeIdx  = k;
        end
        if (!rstB) begin
            expDv.delete();
            expEnd.delete();
            for (int k = 0; k < 7; k++) oeRun[k] = 0;
            prevDone = 1'b0;
        end else begin
            checkOutput("renAtMostOneLow", ($countones(renLow) <= 1) ? 1 : 0, 1);
            checkOutput("oeAtMostOneLow", ($countones(oeLow) <= 1) ? 1 : 0, 1);
            checkOutput("dvFollowsRen", int'(dv), (renIdx >= 0) ? 1 : 0);
            checkOutput("popWithDone", int'(pop), int'(done));
            if (prevDone) checkOutput("busyDropsAfterDone", int'(busy), 0);
            if (renIdx >= 0) begin
                checkOutput("oeLowWithRen", int'(oeLow[renIdx]), 1);
                checkOutput("oeLeadsRen", int'(prevOeLow[renIdx]), 1);
                checkOutput("holdLowBeforeRen", int'(prevHold), 0);
                checkOutput("readExpected", (expDv.size() > 0) ? 1 : 0, 1);
                if (expDv.size() > 0) checkOutput("readFifoOrder", renIdx, expDv.pop_front());
            end
            if (startI && !busy) begin
                acceptCycle = cycle;
                for (int k = 0; k < 7; k++) consumed[k] = 0;
            end
            for (int k = 0; k < 7; k++) begin
                if (oeLow[k]) begin
                    oeRun[k]++;
                end else begin
                    if (oeRun[k] > 0 && expEnd.size() > 0 && expEnd[0].tmo[k])
                        checkOutput("timeoutOeCycles", oeRun[k], TMO + 1);
                    oeRun[k] = 0;
                end
            end
            if (done) begin
                doneSeen++;
                checkOutput("doneExpected", (expEnd.size() > 0) ? 1 : 0, 1);
                if (expEnd.size() > 0) begin
                    e = expEnd.pop_front();
                    checkOutput("doneWcnt", int'(wcnt), e.wcnt);
                    checkOutput("doneTmoerr", int'(tmoerr), int'(e.tmo));
                    checkOutput("busyAtDone", int'(busy), 1);
                    checkOutput("readsLeftAtDone", expDv.size(), 0);
                    if (e.zeroMask) checkOutput("emptyEventLatency", cycle - acceptCycle, 2);
                end
            end
            prevDone = done;
        end
        holdNext  = 1'b0;
        fforStall = 1'b0;
        if (stimMode == 1) begin
            if (stallRun < 3 && $urandom_range(0, 3) == 0) begin
                stallRun++;
                if ($urandom_range(0, 1) == 1) holdNext = 1'b1;
                else fforStall = 1'b1;
            end else begin
                stallRun = 0;
            end
        end else if (stimMode == 2) begin
            holdNext = ((cycle % 2) == 1);
        end
        for (int k = 0; k < 7; k++)
            fforB[k] = ((loaded[k] - consumed[k]) > 0 && !fforStall) ? 1'b0 : 1'b1;
        lastI = (oeIdx >= 0) && ((loaded[oeIdx] - consumed[oeIdx]) == 1);
        holdI = holdNext;
        if (renIdx >= 0) consumed[renIdx]++;
        prevHold  = holdI;
        prevOeLow = oeLow;
    end

    task automatic queueEvent(input logic [6:0] mask, input int cnt[7], output endRec_t e);
        e.wcnt     = 0;
        e.tmo      = '0;
        e.zeroMask = (mask == 7'd0);
        for (int k = 0; k < 7; k++) begin
            loaded[k] = mask[k] ? cnt[k] : 0;
            if (mask[k]) begin
                if (cnt[k] > 0) begin
                    for (int w = 0; w < cnt[k]; w++) expDv.push_back(k);
                    e.wcnt += cnt[k];
                end else begin
                    e.tmo[k] = 1'b1;
                end
            end
        end
        expEnd.push_back(e);
    endtask

    // START stays high one extra cycle so the busy-time ignore path is exercised.
    task automatic pulseStart(input logic [6:0] mask);
        @(posedge clk); #1;
        startI   = 1'b1;
        davmaskI = mask;
        @(posedge clk); #1;
        @(posedge clk); #1;
        startI = 1'b0;
    endtask

    task automatic applyStimulus(input logic [6:0] mask, input int cnt[7], input int mode);
        endRec_t e;
        int      target;
        stimMode = mode;
        target   = doneSeen + 1;
        queueEvent(mask, cnt, e);
        pulseStart(mask);
        for (int c = 0; c < 3000 && doneSeen < target; c++) @(posedge clk);
        checkOutput("eventCompletes", (doneSeen >= target) ? 1 : 0, 1);
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("wcntHeldAfterDone", int'(wcnt), e.wcnt);
        checkOutput("tmoerrHeldAfterDone", int'(tmoerr), int'(e.tmo));
        checkOutput("idleAfterDone", int'(busy), 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "RenB"}, int'(renB), 32'h7F);
        checkOutput({tag, "OeB"}, int'(oeB), 32'h7F);
        checkOutput({tag, "Dv"}, int'(dv), 0);
        checkOutput({tag, "Busy"}, int'(busy), 0);
        checkOutput({tag, "Done"}, int'(done), 0);
        checkOutput({tag, "Pop"}, int'(pop), 0);
        checkOutput({tag, "Wcnt"}, int'(wcnt), 0);
    endtask

    initial begin
        int      cnt[7];
        endRec_t e;
        logic [6:0] mask;
        rstB     = 1'b0;
        startI   = 1'b0;
        davmaskI = '0;
        for (int k = 0; k < 7; k++) begin
            loaded[k]   = 0;
            consumed[k] = 0;
            oeRun[k]    = 0;
        end
        repeat (3) begin @(posedge clk); #1; end
        checkResetOutputs("reset");
        checkOutput("resetTmoerr", int'(tmoerr), 0);
        rstB = 1'b1;
        repeat (2) @(posedge clk);

        cnt = '{3, 0, 3, 0, 0, 0, 0};
        applyStimulus(7'b0000101, cnt, 0);
        cnt = '{0, 0, 0, 0, 0, 0, 0};
        applyStimulus(7'b0000000, cnt, 0);
        applyStimulus(7'b0000010, cnt, 0);
        cnt = '{0, 0, 0, 10, 0, 0, 0};
        applyStimulus(7'b0001000, cnt, 2);

        for (int n = 0; n < 12; n++) begin
            mask = 7'($urandom_range(0, 127));
            for (int k = 0; k < 7; k++)
                cnt[k] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 6));
            applyStimulus(mask, cnt, 1);
        end

        // Abort an event while the second FIFO is being read.
        stimMode = 0;
        cnt = '{3, 0, 0, 6, 0, 0, 0};
        queueEvent(7'b0001001, cnt, e);
        pulseStart(7'b0001001);
        for (int c = 0; c < 500 && renB[3] !== 1'b0; c++) begin @(posedge clk); #1; end
        checkOutput("reachedSecondFifoRead", int'(renB[3] == 1'b0), 1);
        rstB = 1'b0;
        @(posedge clk); #1;
        checkResetOutputs("midReset");
        rstB = 1'b1;
        for (int k = 0; k < 7; k++) loaded[k] = 0;
        repeat (6) begin @(posedge clk); #1; end
        checkOutput("stillIdleAfterAbort", int'(busy), 0);
        checkOutput("abortedWcntCleared", int'(wcnt), 0);

        cnt = '{0, 0, 0, 0, 0, 0, 4};
        applyStimulus(7'b1000000, cnt, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
